// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control slice.
// Optional feature macro: STOPWATCH_SATURATE_EN (stop at 99:59 instead of wrapping).
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_DONE    = 2'b11
  } sw_state_t;

  localparam logic [7:0] MAX_SECS = 8'd59;
  localparam logic [7:0] MAX_MINS = 8'd99;

  localparam int DEFAULT_TICK_DIV = 100_000_000;

  // True when the displayed time sits at the last representable value.
  function automatic logic at_max_time(input logic [7:0] s, input logic [7:0] m);
    return (s == MAX_SECS) && (m == MAX_MINS);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV cycles while run is high.
// With STOPWATCH_SATURATE_EN, also reports when the next advance would fire a tick.
module tick_prescaler
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic sync_clr,
`ifdef STOPWATCH_SATURATE_EN
  output logic at_last,
`endif
  output logic tick
);

  // TICK_DIV must be at least 2 so the counter has a non-zero width.
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // Not advancing (run low, no clear) holds the phase so a pause resumes mid-second.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (sync_clr) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (run) begin
      if (count == LAST) begin
        count <= '0;
        tick  <= 1'b1;
      end else begin
        count <= count + CW'(1);
        tick  <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

`ifdef STOPWATCH_SATURATE_EN
  assign at_last = (count == LAST);
`endif

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button press detection, IDLE/RUNNING/PAUSED(/DONE) FSM, 1 s tick.
// Optional feature macro: STOPWATCH_SATURATE_EN (enter DONE instead of wrapping past 99:59).
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       reset_btn,
  input  logic [7:0] secs,
  input  logic [7:0] mins,
  output logic       count_en,
  output logic       clear,
  output logic       tick,
  output logic [1:0] state
);

  sw_state_t cur;

  logic start_prev, stop_prev, reset_prev;
  logic start_press, stop_press, reset_press;
  logic sat_hit;
  logic run;
  logic sync_clr;

  assign start_press = start_btn & ~start_prev;
  assign stop_press  = stop_btn  & ~stop_prev;
  assign reset_press = reset_btn & ~reset_prev;

`ifdef STOPWATCH_SATURATE_EN
  logic at_last;
  // The tick about to fire would roll 99:59 over; stop there instead.
  assign sat_hit = (cur == ST_RUNNING) && at_last && at_max_time(secs, mins)
                   && !reset_press && !stop_press;
`else
  logic unused_time;
  assign unused_time = ^{secs, mins};
  assign sat_hit     = 1'b0;
`endif

  // Advance only on edges that keep us in RUNNING, so a tick can never land
  // in a cycle where count_en has already dropped.
  assign run      = (cur == ST_RUNNING) && !reset_press && !stop_press && !sat_hit;
  assign sync_clr = reset_press || (cur == ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur        <= ST_IDLE;
      start_prev <= 1'b0;
      stop_prev  <= 1'b0;
      reset_prev <= 1'b0;
      count_en   <= 1'b0;
      clear      <= 1'b0;
    end else begin
      start_prev <= start_btn;
      stop_prev  <= stop_btn;
      reset_prev <= reset_btn;
      clear      <= reset_press;
      if (reset_press) begin
        cur      <= ST_IDLE;
        count_en <= 1'b0;
      end else begin
        case (cur)
          ST_IDLE: begin
            if (start_press) begin
              cur      <= ST_RUNNING;
              count_en <= 1'b1;
            end
          end
          ST_RUNNING: begin
            if (stop_press) begin
              cur      <= ST_PAUSED;
              count_en <= 1'b0;
            end else if (sat_hit) begin
              cur      <= ST_DONE;
              count_en <= 1'b0;
            end
          end
          ST_PAUSED: begin
            // Stop outranks start, so a simultaneous pair leaves us paused.
            if (start_press && !stop_press) begin
              cur      <= ST_RUNNING;
              count_en <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign state = cur;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .sync_clr(sync_clr),
`ifdef STOPWATCH_SATURATE_EN
    .at_last (at_last),
`endif
    .tick    (tick)
  );

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with TICK_DIV=4: per-cycle model comparison plus directed literal checks.
module tb_stopwatch_ctrl;

  localparam int TD = 4;
`ifdef STOPWATCH_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       start_btn, stop_btn, reset_btn;
  logic [7:0] secs, mins;
  logic       count_en, clear, tick;
  logic [1:0] state;

  int n_vec = 0;
  int n_err = 0;

  stopwatch_ctrl #(.TICK_DIV(TD)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_btn(start_btn),
    .stop_btn (stop_btn),
    .reset_btn(reset_btn),
    .secs     (secs),
    .mins     (mins),
    .count_en (count_en),
    .clear    (clear),
    .tick     (tick),
    .state    (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model. States: 0 idle, 1 running, 2 paused, 3 done.
  int m_state, m_cnt;
  bit m_en, m_clear, m_tick;
  bit m_pstart, m_pstop, m_preset;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0; m_cnt = 0; m_en = 0; m_clear = 0; m_tick = 0;
      m_pstart = 0; m_pstop = 0; m_preset = 0;
    end else begin
      bit ps, pp, pr, hit, keep;
      int nxt;
      ps = start_btn && !m_pstart;
      pp = stop_btn  && !m_pstop;
      pr = reset_btn && !m_preset;
      m_pstart = start_btn; m_pstop = stop_btn; m_preset = reset_btn;
      hit = SAT && (m_state == 1) && !pr && !pp && (m_cnt == TD - 1)
            && (secs == 8'd59) && (mins == 8'd99);
      nxt = m_state;
      if (pr) nxt = 0;
      else if (m_state == 0 && ps) nxt = 1;
      else if (m_state == 1 && pp) nxt = 2;
      else if (hit) nxt = 3;
      else if (m_state == 2 && ps && !pp) nxt = 1;
      keep = (m_state == 1) && (nxt == 1);
      m_tick = 0;
      if (nxt == 0) m_cnt = 0;
      else if (keep) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == TD) begin
          m_cnt  = 0;
          m_tick = 1;
        end
      end
      m_clear = pr;
      m_en    = (nxt == 1);
      m_state = nxt;
    end
  end

  // scoreboard compare, every cycle on the falling edge
  always @(negedge clk) begin
    check("state",    state,    m_state);
    check("count_en", count_en, m_en);
    check("clear",    clear,    m_clear);
    check("tick",     tick,     m_tick);
    check("prescale", int'(dut.u_prescaler.count), m_cnt);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int nt, t1, t2;

  initial begin
    rst = 1'b1; start_btn = 0; stop_btn = 0; reset_btn = 0; secs = 0; mins = 0;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    check("lit_rst_state", state, 0);
    check("lit_rst_en",    count_en, 0);
    check("lit_rst_tick",  tick, 0);
    check("lit_rst_clear", clear, 0);

    // start, two ticks, pause, resume
    start_btn = 1; cyc(1);
    check("lit_start_state", state, 1);
    check("lit_start_en", count_en, 1);
    check("lit_start_pre", int'(dut.u_prescaler.count), 0);
    start_btn = 0;
    nt = 0; t1 = 0; t2 = 0;
    for (int i = 1; i <= 9; i++) begin
      cyc(1);
      if (tick) begin
        nt++;
        if (nt == 1) t1 = i;
        else if (nt == 2) t2 = i;
      end
    end
    check("lit_tick_count", nt, 2);
    check("lit_tick1_at", t1, 4);
    check("lit_tick2_at", t2, 8);
    cyc(1);
    stop_btn = 1; cyc(1);
    check("lit_pause_state", state, 2);
    check("lit_pause_pre", int'(dut.u_prescaler.count), 2);
    stop_btn = 0; cyc(3);
    check("lit_pause_hold", int'(dut.u_prescaler.count), 2);
    start_btn = 1; cyc(1);
    check("lit_resume_state", state, 1);
    start_btn = 0; cyc(1);
    check("lit_resume_tick_early", tick, 0);
    cyc(1);
    check("lit_resume_tick", tick, 1);

    // priority
    start_btn = 1; stop_btn = 1; cyc(1);
    check("lit_startstop_run", state, 2);
    start_btn = 0; stop_btn = 0; cyc(1);
    reset_btn = 1; start_btn = 1; cyc(1);
    check("lit_resetstart_state", state, 0);
    check("lit_resetstart_clear", clear, 1);
    reset_btn = 0; start_btn = 0; cyc(1);
    check("lit_clear_one_cycle", clear, 0);

    // tick/clear conflict
    start_btn = 1; cyc(1);
    start_btn = 0; cyc(3);
    check("lit_conf_pre3", int'(dut.u_prescaler.count), 3);
    reset_btn = 1; cyc(1);
    check("lit_conf_tick", tick, 0);
    check("lit_conf_clear", clear, 1);
    check("lit_conf_pre", int'(dut.u_prescaler.count), 0);
    check("lit_conf_state", state, 0);
    reset_btn = 0; cyc(1);

    // held start, then stop: no new start edge
    start_btn = 1; cyc(20);
    check("lit_held_run", state, 1);
    stop_btn = 1; cyc(1);
    check("lit_held_pause", state, 2);
    stop_btn = 0; cyc(3);
    check("lit_held_stay", state, 2);
    start_btn = 0; reset_btn = 1; cyc(1);
    reset_btn = 0;

    // asynchronous reset mid-run, start held through release
    start_btn = 1; cyc(1);
    start_btn = 0; cyc(2);
    #2 rst = 1'b1;
    #1;
    check("lit_arst_state", state, 0);
    check("lit_arst_en", count_en, 0);
    check("lit_arst_tick", tick, 0);
    check("lit_arst_clear", clear, 0);
    check("lit_arst_pre", int'(dut.u_prescaler.count), 0);
    start_btn = 1;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    check("lit_arst_release_start", state, 1);
    start_btn = 0;
    reset_btn = 1; cyc(1);
    reset_btn = 0; cyc(1);

    // 99:59 behaviour
    secs = 8'd59; mins = 8'd99;
    start_btn = 1; cyc(1);
    start_btn = 0; cyc(3);
    check("lit_sat_pre_tick", tick, 0);
    cyc(1);
`ifdef STOPWATCH_SATURATE_EN
    check("lit_sat_state", state, 3);
    check("lit_sat_tick", tick, 0);
    check("lit_sat_en", count_en, 0);
    start_btn = 1; stop_btn = 1; cyc(1);
    check("lit_sat_ignore", state, 3);
    start_btn = 0; stop_btn = 0; cyc(1);
    reset_btn = 1; cyc(1);
    check("lit_sat_exit_state", state, 0);
    check("lit_sat_exit_clear", clear, 1);
    reset_btn = 0;
`else
    check("lit_wrap_tick", tick, 1);
    check("lit_wrap_state", state, 1);
    check("lit_wrap_en", count_en, 1);
    reset_btn = 1; cyc(1);
    check("lit_wrap_reset", state, 0);
    reset_btn = 0;
`endif
    secs = 0; mins = 0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control sequencer for the stopwatch datapath. Turns start/stop/reset button levels into a RUN/PAUSE/IDLE state machine and generates a 1-second tick. Drives the shared `count_en` and synchronous `clear` inputs of the seconds and minutes counters. Sits between the button synchronisers and the counter chain; the tick feeds the seconds counter's increment input.

## Interface
- `TICK_DIV`, default 100_000_000: clock cycles per tick; must be ≥2.
- `clk`  in  1: system clock, rising edge.
- `rst`  in  1: asynchronous, active-high global reset.
- `start_btn`  in  1: start/resume request; synchronised level.
- `stop_btn`  in  1: pause request; synchronised level.
- `reset_btn`  in  1: user clear request; synchronised level.
- `secs`  in  8: current seconds value, 0–59; used only with the saturate feature.
- `mins`  in  8: current minutes value, 0–99; used only with the saturate feature.
- `count_en`  out  1: counter enable; high iff the state is RUNNING.
- `clear`  out  1: one-cycle synchronous clear pulse to both counters.
- `tick`  out  1: one-cycle increment pulse to the seconds counter.
- `state`  out  2: IDLE=00, RUNNING=01, PAUSED=10, DONE=11.

## Operation
- **Press detection.** Each button has a previous-value register, reset to 0. A press is `btn & ~prev`. A button held high through reset release therefore registers one press.
- **Press priority, same cycle:** reset > stop > start.
- **State transitions:**
  - IDLE: start → RUNNING; stop is ignored.
  - RUNNING: stop → PAUSED.
  - PAUSED: start → RUNNING.
  - Any state: reset → IDLE and `clear` is pulsed. This includes reset pressed while already in IDLE.
  - Simultaneous start+stop: in RUNNING → PAUSED; in PAUSED → stays PAUSED; in IDLE → RUNNING (stop ignored, start acts).
- **Prescaler:** counter of width $clog2(TICK_DIV).
  - RUNNING: increments each cycle. When it equals TICK_DIV-1, it wraps to 0 and `tick` is pulsed.
  - PAUSED: holds its value, preserving the sub-second phase.
  - IDLE, or on a reset press: set to 0.
- **Conflict:** a reset press in the same cycle a tick would fire suppresses the tick. `clear` wins.
- All outputs are registered.
- **Reset (`rst`) values:** state=IDLE, `count_en`=0, `clear`=0, `tick`=0, prescaler=0.

## Timing
- Press first sampled high at edge k → new `state`/`count_en` visible after edge k. One cycle of latency from the input being high.
- `clear` is high for exactly the one cycle following edge k, then returns to 0.
- From an accepted start with prescaler=0, the first `tick` follows TICK_DIV edges. Subsequent ticks occur every TICK_DIV cycles while RUNNING.
- `tick` is never high unless `count_en` is high in the same cycle.
- `rst` asserted mid-count forces all outputs to their reset values immediately, without waiting for a clock edge.

## Configuration
- Macro: `STOPWATCH_SATURATE_EN`.
- **Defined:**
  - In RUNNING, when a tick would fire with `secs`==59 and `mins`==99, the tick is suppressed and the state goes to DONE.
  - In DONE, `count_en`=0 and the prescaler holds. Only a reset press exits, going to IDLE with a `clear` pulse. Start and stop are ignored.
- **Undefined:** DONE is unreachable and the state value 11 is never produced. `secs`/`mins` are unused. The counters wrap 99:59 → 00:00 on the normal tick.

## Structure
- Shared package `stopwatch_pkg` holds:
  - state encodings (IDLE/RUNNING/PAUSED/DONE);
  - `MAX_SECS`=59 and `MAX_MINS`=99;
  - default `TICK_DIV`.
- Sub-module `tick_prescaler`, with this interface:
  - inputs: `clk`, `rst`, `run`, `sync_clr`;
  - output: `tick`;
  - parameter: `TICK_DIV`.
- The FSM and press detection stay in `stopwatch_ctrl`.

## Test plan
All scenarios use TICK_DIV=4.
- **Reset values.** Assert `rst` mid-RUNNING → outputs are 0 and state=00 without a clock edge. Release `rst` and hold start high → next edge gives state=01.
- **Start/pause/resume.** Start press, wait 9 cycles → exactly 2 ticks, at cycles 4 and 8 after the start is accepted. Stop after 2 more cycles → state=10 with prescaler=2 held. Start again → next tick 2 cycles later.
- **Priority.** Start+stop in the same cycle while RUNNING → state=10. Reset+start in the same cycle while PAUSED → state=00, `clear`=1 for one cycle.
- **Tick/clear conflict.** Reset press on the cycle the prescaler reaches 3 → `tick`=0, `clear`=1, prescaler=0, state=00.
- **Held button.** Hold start high for 20 cycles from IDLE; stop press; start still held → state stays 10, because there is no new rising edge.
- **With `STOPWATCH_SATURATE_EN`.** Drive `secs`=59, `mins`=99 while RUNNING → no tick, state=11, `count_en`=0. Start/stop are ignored. Reset press → state=00 with a `clear` pulse.
- **Without `STOPWATCH_SATURATE_EN`.** Same stimulus → tick fires normally and state stays 01.
